mod_deser_block: RTL
====================

# mod_deser_block

Parametrised serial-to-parallel block assembler. It collects `ELEMS` elements of `ELEM_W` bits, arriving one per accepted beat, into one wide block. The block is then presented downstream through a valid/ready output register. The default configuration turns a byte stream into a 128-bit AES state (16 × 8). On top of plain assembly it adds input backpressure, an output holding stage so collection overlaps drain, a flush of partial blocks with zero padding, and a selectable element order.

## Interface
- `ELEM_W`, 8, element width in bits (≥1)
- `ELEMS`, 16, elements per block (≥2)
- `MSB_FIRST`, 1, 1: element 0 lands in the top slice `out_data[ELEMS*ELEM_W-1 -: ELEM_W]`; 0: element 0 lands in `out_data[ELEM_W-1:0]`
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `in_valid`  in  1  `in_data` holds an element
- `in_ready`  out  1  block can accept an element this cycle (combinational)
- `in_data`  in  ELEM_W  input element
- `flush`  in  1  single-cycle request to emit the current partial block
- `out_valid`  out  1  `out_data`/`out_count` hold a block
- `out_ready`  in  1  downstream consumes the block this cycle
- `out_data`  out  ELEMS*ELEM_W  assembled block
- `out_count`  out  $clog2(ELEMS+1)  number of real elements in block (ELEMS for full, 1..ELEMS-1 for flushed)
- `flush_pend`  out  1  flush requested, not yet serviced

## Operation
- Internal state:
  - collect buffer `aux[ELEMS]`
  - fill counter `cnt`, range 0..ELEMS-1
  - output register: `out_data`, `out_count`, `out_valid`
  - `flush_pend` flag
- Accept = `in_valid && in_ready`. Slot free = `!out_valid || out_ready`.
- `in_ready` = `!(cnt==ELEMS-1 || flush_pend) || slot_free`. Only the completing element, or any element while a flush is pending, waits for the output slot.
- On accept with `cnt < ELEMS-1` and no flush service:
  - `aux[cnt] <= in_data`
  - `cnt <= cnt+1`
- On accept with `cnt == ELEMS-1`:
  - Output register loads `aux[0..ELEMS-2]` plus `in_data` as the last element.
  - `out_count <= ELEMS`, `out_valid <= 1`.
  - `cnt` wraps to 0.
  - `aux` is cleared to 0.
- Flush:
  - A `flush` pulse sets `flush_pend`.
  - Service occurs on the first cycle (including the pulse cycle) with `flush_pend||flush` and slot free.
  - Let n = `cnt` + (accept this cycle ? 1 : 0).
  - If n == 0: nothing is emitted and `flush_pend` clears.
  - If n > 0: the output loads elements 0..n-1, elements n..ELEMS-1 are zero, `out_count <= n`, `out_valid <= 1`, `cnt <= 0`, `aux` cleared, `flush_pend` clears.
  - If n == ELEMS, the result is identical to a normal completion with `out_count = ELEMS`.
  - A `flush` while `flush_pend` is already set is absorbed; no second block is produced.
- Output drain: when `out_valid && out_ready` and no new load occurs, `out_valid <= 0`. `out_data` and `out_count` hold their last values.
- Simultaneous drain and load in one cycle:
  - The new block replaces the old one.
  - `out_valid` stays 1.
  - No bubble is inserted and no block is lost.
- Element placement:
  - `MSB_FIRST=1`: element k goes to slice `(ELEMS-1-k)`.
  - `MSB_FIRST=0`: element k goes to slice k.
  - Padding always fills the slices of the missing elements.
- `in_data` is ignored when `in_valid=0`. An element offered while `in_ready=0` is not consumed and must be held by the source.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_count=0`, `flush_pend=0`
  - `cnt=0`, `aux=0`
  - `in_ready=1` once reset deasserts
- Latency: the completing element is accepted at edge k; `out_valid=1` with the full block is visible after edge k (1 cycle).
- Throughput: one element per cycle sustained, provided downstream accepts one block per ELEMS cycles.
- Flush latency: 1 cycle after the servicing edge. When the slot is busy, service occurs on the cycle `out_ready` rises.
- Reset asserted mid-block or with a block waiting: the partial block and the pending output are discarded and all outputs return to reset values asynchronously.
- `out_data` and `out_count` are stable while `out_valid && !out_ready`.

## Test plan
- Stream bytes 0x00..0x1F back-to-back with `out_ready=1` (defaults) -> two blocks, each `out_count=16`: first `out_data=128'h000102…0F`, second `128'h101112…1F`, each `out_valid` one cycle after the 16th/32nd accept.
- Fill one block, hold `out_ready=0`, continue streaming -> 15 further elements accepted, `in_ready=0` while the 16th is offered; raise `out_ready` -> first block drains and second loads in the same edge, `out_valid` stays 1.
- Send 0xAA,0xBB,0xCC then pulse `flush` -> `out_count=3`, `out_data=128'hAABBCC00…00`; with `MSB_FIRST=0` -> `128'h00…00CCBBAA`.
- Pulse `flush` with `cnt=0` -> no `out_valid`, `flush_pend` low next cycle; pulse `flush` in the same cycle as the 5th accept -> `out_count=5`.
- Pulse `flush` while the output slot is occupied -> `flush_pend=1`, `in_ready=0` until `out_ready`, then partial block emitted.
- Assert `reset` after 7 elements with a block pending -> `out_valid=0`, `out_data=0`; the next 16 elements form a clean block starting at element 0.

Source files
------------

// File: rtl/mod_deser_block_if.sv
// Handshake bundle for the serial-to-parallel block assembler.
// Source/sink side is master, the assembler itself is slave.
interface mod_deser_block_if #(
  parameter int ELEM_W = 8,
  parameter int ELEMS  = 16
);
  localparam int CW = $clog2(ELEMS + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [ELEM_W-1:0]       in_data;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [ELEMS*ELEM_W-1:0] out_data;
  logic [CW-1:0]           out_count;
  logic                    flush_pend;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count, flush_pend
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, flush_pend
  );
endinterface

// File: rtl/mod_deser_block.sv
// Collects ELEMS elements into one block behind a valid/ready
// output register, with zero-padded flush of partial blocks.
module mod_deser_block #(
  parameter int ELEM_W    = 8,
  parameter int ELEMS     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mod_deser_block_if.slave bus
);
  localparam int BW = ELEMS * ELEM_W;
  localparam int CW = $clog2(ELEMS + 1);
  localparam int NW = $clog2(ELEMS);

  logic [NW-1:0]     cnt_q, cnt_d;
  logic [ELEM_W-1:0] aux_q [ELEMS];
  logic [ELEM_W-1:0] aux_d [ELEMS];
  logic [BW-1:0]     data_q, data_d;
  logic [CW-1:0]     count_q, count_d;
  logic              valid_q, valid_d;
  logic              pend_q, pend_d;

  logic              slot_free;
  logic              last;
  logic              in_rdy;
  logic              acc;
  logic              fl_req;
  logic              svc;
  logic              load;
  logic [CW-1:0]     n;
  logic [BW-1:0]     blk;
  logic [ELEM_W-1:0] elem;

  // Only the completing element, or any element behind a pending
  // flush, has to wait for the output slot.
  assign slot_free = !valid_q || bus.out_ready;
  assign last      = (cnt_q == NW'(ELEMS - 1));
  assign in_rdy    = !(last || pend_q) || slot_free;
  assign acc       = bus.in_valid && in_rdy;
  assign fl_req    = pend_q || bus.flush;
  assign svc       = fl_req && slot_free;
  assign n         = CW'(cnt_q) + CW'(acc);
  assign load      = (acc && last) || (svc && (n != '0));

  // Candidate block: stored elements plus the one arriving now.
  // Slots at or above cnt are always zero, which gives the padding.
  always_comb begin
    blk  = '0;
    elem = '0;
    for (int k = 0; k < ELEMS; k++) begin
      elem = aux_q[k];
      if (acc && (k == int'(cnt_q)))
        elem = bus.in_data;
      if (MSB_FIRST)
        blk[(ELEMS-1-k)*ELEM_W +: ELEM_W] = elem;
      else
        blk[k*ELEM_W +: ELEM_W] = elem;
    end
  end

  // Next state: a load wins over a drain so no bubble appears.
  always_comb begin
    cnt_d   = cnt_q;
    aux_d   = aux_q;
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    pend_d  = fl_req && !svc;
    if (valid_q && bus.out_ready)
      valid_d = 1'b0;
    if (load) begin
      data_d  = blk;
      count_d = n;
      valid_d = 1'b1;
      cnt_d   = '0;
      for (int k = 0; k < ELEMS; k++)
        aux_d[k] = '0;
    end else if (acc) begin
      aux_d[cnt_q] = bus.in_data;
      cnt_d        = cnt_q + NW'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      for (int k = 0; k < ELEMS; k++)
        aux_q[k] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      aux_q   <= aux_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.out_count  = count_q;
  assign bus.flush_pend = pend_q;

endmodule
